// File: rtl/positron_argmax_pkg.sv
// -----------------------------------------------------------------------------
// positron_argmax_pkg
// Shared posit definitions for the classification stage:
//   - positron_argmax_state_t : FSM state encoding of the argmax stage
//   - posit_nar(width)        : NaR pattern (MSB set, all other bits zero)
// -----------------------------------------------------------------------------
package positron_argmax_pkg;

    // Widest posit the helper function can describe.
    localparam int POSIT_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } positron_argmax_state_t;

    // NaR is a single 1 in the sign position followed by zeros; callers cast
    // the result down to their own posit width.
    function automatic logic [POSIT_MAX_WIDTH-1:0] posit_nar(input int width);
        return POSIT_MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/positron_argmax_posit_gt.sv
// -----------------------------------------------------------------------------
// posit_gt
// Combinational exact posit comparison. Posits order like two's-complement
// integers, so a signed compare is exact and NaR sorts as the minimum.
// Ports:
//   a, b    : posits to compare
//   a_gt_b  : 1 when a is strictly greater than b
// -----------------------------------------------------------------------------
module posit_gt #(
    parameter int POSIT_WIDTH = 16
) (
    input  logic [POSIT_WIDTH-1:0] a,
    input  logic [POSIT_WIDTH-1:0] b,
    output logic                   a_gt_b
);

    assign a_gt_b = $signed(a) > $signed(b);

endmodule

// File: rtl/positron_argmax.sv
// -----------------------------------------------------------------------------
// positron_argmax
// Output-classification stage: consumes one window of NB_POSITRON posits
// framed by sow/eow, tracks the running maximum and emits a single-beat
// result with the winning neuron index, its value, a NaR flag and a
// window-length error flag.
//
// State table
//   state | meaning
//   IDLE  | waiting for a beat with sow_i; other beats are dropped
//   ACC   | accumulating the window, tracking max / index / count / NaR
//   OUT   | result presented on rts_o, held until rtr_i
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rtr_o               : ready to receive (upstream handshake)
//   rts_i, sow_i, eow_i : upstream valid and window framing
//   posit_i             : neuron output posit
//   rtr_i               : downstream ready
//   rts_o, sow_o, eow_o : result valid; sow/eow mark the single-beat result
//   class_o, posit_o    : index and value of the maximum
//   nar_o               : at least one NaR seen in the window
//   len_err_o           : window length differed from NB_POSITRON
// -----------------------------------------------------------------------------
module positron_argmax
    import positron_argmax_pkg::*;
#(
    parameter  int NB_POSITRON = 20,
    parameter  int POSIT_WIDTH = 16,
    parameter  int POSIT_ES    = 0,
    localparam int IDX_WIDTH   = $clog2(NB_POSITRON)
) (
    input  logic                   clk,
    input  logic                   rst_n,

    output logic                   rtr_o,
    input  logic                   rts_i,
    input  logic                   sow_i,
    input  logic                   eow_i,
    input  logic [POSIT_WIDTH-1:0] posit_i,

    input  logic                   rtr_i,
    output logic                   rts_o,
    output logic                   sow_o,
    output logic                   eow_o,
    output logic [IDX_WIDTH-1:0]   class_o,
    output logic [POSIT_WIDTH-1:0] posit_o,
    output logic                   nar_o,
    output logic                   len_err_o
);

    localparam int                    CNT_WIDTH = IDX_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_FULL  = CNT_WIDTH'(NB_POSITRON);
    localparam logic [POSIT_WIDTH-1:0] NAR      = POSIT_WIDTH'(posit_nar(POSIT_WIDTH));

    if (NB_POSITRON < 2) begin : g_bad_nb
        $error("positron_argmax: NB_POSITRON must be at least 2");
    end
    if (POSIT_ES < 0) begin : g_bad_es
        $error("positron_argmax: POSIT_ES must be non-negative");
    end

    positron_argmax_state_t r_state;
    positron_argmax_state_t w_state_nxt;

    logic                   r_rdy;
    logic [POSIT_WIDTH-1:0] r_max;
    logic [IDX_WIDTH-1:0]   r_idx;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_nar;
    logic                   r_len_err;

    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic                   w_is_nar;
    logic                   w_gt;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;
    logic                   w_load;
    logic                   w_acc;
    logic                   w_close;
    logic                   w_len_err_nxt;

    posit_gt #(
        .POSIT_WIDTH (POSIT_WIDTH)
    ) u_posit_gt (
        .a      (posit_i),
        .b      (r_max),
        .a_gt_b (w_gt)
    );

    // r_rdy keeps rtr_o low while reset is held and for nothing else; it
    // rises on the first clock after release. rtr_o depends only on state,
    // so there is no path from rtr_i.
    assign rtr_o      = r_rdy & (r_state != OUT);
    assign w_in_xfer  = rts_i & rtr_o;
    assign w_out_xfer = rts_o & rtr_i;
    assign w_is_nar   = (posit_i == NAR);
    assign w_cnt_inc  = (r_cnt == CNT_FULL) ? r_cnt : r_cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy   <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_acc         = 1'b0;
        w_close       = 1'b0;
        w_len_err_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_in_xfer && sow_i) begin
                    w_load = 1'b1;
                    if (eow_i) begin
                        // One-element window: always a length error.
                        w_close       = 1'b1;
                        w_len_err_nxt = 1'b1;
                        w_state_nxt   = OUT;
                    end else begin
                        w_state_nxt = ACC;
                    end
                end
            end
            ACC: begin
                if (w_in_xfer) begin
                    if (sow_i) begin
                        // Restart: the partial window is discarded.
                        w_load = 1'b1;
                        if (eow_i) begin
                            w_close       = 1'b1;
                            w_len_err_nxt = 1'b1;
                            w_state_nxt   = OUT;
                        end
                    end else begin
                        w_acc = 1'b1;
                        if (eow_i || (w_cnt_inc == CNT_FULL)) begin
                            // Closing on a full count without eow_i is also
                            // flagged; the trailing beats get dropped in IDLE.
                            w_close       = 1'b1;
                            w_len_err_nxt = !eow_i || (w_cnt_inc != CNT_FULL);
                            w_state_nxt   = OUT;
                        end
                    end
                end
            end
            OUT: begin
                if (w_out_xfer) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_nar     <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            if (w_load) begin
                r_max <= posit_i;
                r_idx <= '0;
                r_cnt <= CNT_WIDTH'(1);
                r_nar <= w_is_nar;
            end else if (w_acc) begin
                // Strict greater-than: ties keep the earliest index.
                if (w_gt) begin
                    r_max <= posit_i;
                    r_idx <= r_cnt[IDX_WIDTH-1:0];
                end
                r_cnt <= w_cnt_inc;
                r_nar <= r_nar | w_is_nar;
            end

            if (w_close) begin
                r_len_err <= w_len_err_nxt;
            end else if (w_load) begin
                r_len_err <= 1'b0;
            end
        end
    end

    assign rts_o     = (r_state == OUT);
    assign sow_o     = rts_o;
    assign eow_o     = rts_o;
    assign class_o   = r_idx;
    assign posit_o   = r_max;
    assign nar_o     = r_nar;
    assign len_err_o = r_len_err;

endmodule

// File: tb/tb_positron_argmax.sv
module tb_positron_argmax;

    localparam int NB = 20;
    localparam int PW = 16;
    localparam int IW = $clog2(NB);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rtr_o;
    logic          rts_i = 1'b0;
    logic          sow_i = 1'b0;
    logic          eow_i = 1'b0;
    logic [PW-1:0] posit_i = '0;
    logic          rtr_i = 1'b1;
    logic          rts_o;
    logic          sow_o;
    logic          eow_o;
    logic [IW-1:0] class_o;
    logic [PW-1:0] posit_o;
    logic          nar_o;
    logic          len_err_o;

    positron_argmax #(
        .NB_POSITRON (NB),
        .POSIT_WIDTH (PW),
        .POSIT_ES    (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rtr_o     (rtr_o),
        .rts_i     (rts_i),
        .sow_i     (sow_i),
        .eow_i     (eow_i),
        .posit_i   (posit_i),
        .rtr_i     (rtr_i),
        .rts_o     (rts_o),
        .sow_o     (sow_o),
        .eow_o     (eow_o),
        .class_o   (class_o),
        .posit_o   (posit_o),
        .nar_o     (nar_o),
        .len_err_o (len_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cls;
        logic [15:0] val;
        logic        nar;
        logic        len_err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] vals [0:31];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int c, input logic [15:0] v, input logic n, input logic l);
        exp_t e;
        e.cls = c; e.val = v; e.nar = n; e.len_err = l;
        sb_q.push_back(e);
    endtask

    // Monitor: pops one expectation per output transfer.
    always @(negedge clk) begin
        if (rst_n && rts_o && rtr_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: class %0d posit 0x%h, expected no result", class_o, posit_o);
            end else begin
                mon_e = sb_q.pop_front();
                check("class_o",   class_o,   mon_e.cls);
                check("posit_o",   posit_o,   mon_e.val);
                check("nar_o",     nar_o,     mon_e.nar);
                check("len_err_o", len_err_o, mon_e.len_err);
                check("sow_o",     sow_o,     1);
                check("eow_o",     eow_o,     1);
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send_beat(input logic [15:0] d, input logic s, input logic e, input logic close);
        int n = 0;
        posit_i = d; sow_i = s; eow_i = e; rts_i = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!rtr_o && n < 50);
        if (!rtr_o) begin
            checks++;
            errors++;
            $display("FAIL rtr_timeout: rtr_o 0 expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
        rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0;
        if (close) begin
            @(negedge clk);
            check("latency_rts_o", rts_o, 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_window(input int n, input int eow_at, input int close_at);
        for (int i = 0; i < n; i++)
            send_beat(vals[i], i == 0, i == eow_at, i == close_at);
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 32; i++) vals[i] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_rtr_o",     rtr_o,     0);
        check("rst_rts_o",     rts_o,     0);
        check("rst_sow_o",     sow_o,     0);
        check("rst_eow_o",     eow_o,     0);
        check("rst_class_o",   class_o,   0);
        check("rst_posit_o",   posit_o,   0);
        check("rst_nar_o",     nar_o,     0);
        check("rst_len_err_o", len_err_o, 0);
        rst_n = 1'b1;
        #1 check("rtr_o_before_clk", rtr_o, 0);
        @(negedge clk);
        check("rtr_o_after_release", rtr_o, 1);
        @(posedge clk); #1;

        // Single maximum at beat 7
        fill(16'h4000); vals[7] = 16'h6000;
        push_exp(7, 16'h6000, 0, 0);
        send_window(20, 19, 19);

        // Tie keeps the first index
        fill(16'hC000); vals[3] = 16'h6000; vals[12] = 16'h6000;
        push_exp(3, 16'h6000, 0, 0);
        send_window(20, 19, 19);

        // NaR at beat 0 is the minimum
        fill(16'h2000); vals[0] = 16'h8000;
        push_exp(1, 16'h2000, 1, 0);
        send_window(20, 19, 19);

        // All NaR
        fill(16'h8000);
        push_exp(0, 16'h8000, 1, 0);
        send_window(20, 19, 19);

        // Negative values: -256 beats -4096 and the most negative real
        fill(16'hF000); vals[15] = 16'hFF00; vals[16] = 16'h8001;
        push_exp(15, 16'hFF00, 0, 0);
        send_window(20, 19, 19);

        // Short window: eow on beat 9
        fill(16'h1000); vals[4] = 16'h3000;
        push_exp(4, 16'h3000, 0, 1);
        send_window(10, 9, 9);

        // Long window: closes after beat 19, beats 20-24 dropped
        for (int i = 0; i < 32; i++) vals[i] = 16'(i * 16'h0100);
        push_exp(19, 16'h1300, 0, 1);
        send_window(25, -1, 19);

        // One-element window
        push_exp(0, 16'h0500, 0, 1);
        send_beat(16'h0500, 1, 1, 1);

        // Restart mid-window: partial window with a large value is discarded
        fill(16'h1000); vals[2] = 16'h7000;
        send_window(5, -1, -1);
        fill(16'h1000); vals[6] = 16'h3000;
        push_exp(6, 16'h3000, 0, 0);
        send_window(20, 19, 19);

        // Back-pressure: hold rtr_i low for 10 cycles in OUT
        rtr_i = 1'b0;
        fill(16'h7FFF);
        push_exp(0, 16'h7FFF, 0, 0);
        send_window(20, 19, 19);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rts_o",   rts_o,   1);
            check("hold_rtr_o",   rtr_o,   0);
            check("hold_class_o", class_o, 0);
            check("hold_posit_o", posit_o, 16'h7FFF);
        end
        @(posedge clk); #1;
        rtr_i = 1'b1;

        // Reset at beat 11 aborts the window; only the new window reports
        fill(16'h0000); vals[5] = 16'h7000;
        send_window(11, -1, -1);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_rts_o", rts_o, 0);
            check("midrst_rtr_o", rtr_o, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill(16'h0000); vals[2] = 16'h5000;
        push_exp(2, 16'h5000, 0, 0);
        send_window(20, 19, 19);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
